// File: rtl/seg_disp_scheduler_pkg.sv
// Shared types and constants for the display scheduler: FSM states, source codes
// reported on cur_src, and the largest value the 6-digit display can show.
package seg_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW0 = 2'd1,
        ST_SHOW1 = 2'd2,
        ST_ALERT = 2'd3
    } state_t;

    localparam logic [1:0] SRC_IDLE  = 2'd0;
    localparam logic [1:0] SRC_CH0   = 2'd1;
    localparam logic [1:0] SRC_CH1   = 2'd2;
    localparam logic [1:0] SRC_ALERT = 2'd3;

    localparam logic [19:0] DISP_MAX = 20'd999999;

    function automatic logic [1:0] src_of(input state_t s);
        logic [1:0] src;
        case (s)
            ST_SHOW0: src = SRC_CH0;
            ST_SHOW1: src = SRC_CH1;
            ST_ALERT: src = SRC_ALERT;
            default:  src = SRC_IDLE;
        endcase
        return src;
    endfunction

    // Preferred channel first, then the other one; SRC_IDLE as preference favours ch0.
    function automatic state_t return_state(input logic [1:0] pref, input logic v0, input logic v1);
        state_t s;
        if (pref == SRC_CH1)
            s = v1 ? ST_SHOW1 : (v0 ? ST_SHOW0 : ST_IDLE);
        else
            s = v0 ? ST_SHOW0 : (v1 ? ST_SHOW1 : ST_IDLE);
        return s;
    endfunction

endpackage

// File: rtl/seg_disp_scheduler_ms_tick.sv
// Free-running prescaler producing a one-cycle pulse every millisecond.
module ms_tick_gen #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic tick
);
    localparam int DIV = CLK_FREQ_HZ / 1000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_reg;
    logic          tick_reg;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= (cnt_reg == CW'(DIV - 1));
            cnt_reg  <= (cnt_reg == CW'(DIV - 1)) ? '0 : cnt_reg + 1'b1;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/seg_disp_scheduler.sv
// Shares one 6-digit display between two round-robin data channels and a blinking,
// preempting alert source. Outputs are registered from the next state and live inputs.
module seg_disp_scheduler
    import seg_sched_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DWELL_MS    = 2000,
    parameter int ALERT_MS    = 3000,
    parameter int BLINK_MS    = 250
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [19:0] ch0_data,
    input  logic [5:0]  ch0_dp,
    input  logic        ch0_sign,
    input  logic        ch0_vld,
    input  logic [19:0] ch1_data,
    input  logic [5:0]  ch1_dp,
    input  logic        ch1_sign,
    input  logic        ch1_vld,
    input  logic [19:0] alert_data,
    input  logic [5:0]  alert_dp,
    input  logic        alert_sign,
    input  logic        alert_req,
    output logic [19:0] data,
    output logic [5:0]  dp,
    output logic        sign,
    output logic        seg_en,
    output logic [1:0]  cur_src
);
    localparam int TW = 16;

    logic           tick;
    logic           alert_req_reg;
    logic           alert_edge;
    state_t         state_reg, state_next;
    logic [1:0]     ret_reg, ret_next;
    logic [TW-1:0]  dwell_cnt_reg, alert_cnt_reg, blink_cnt_reg;
    logic           dwell_done, alert_done, blink_done;
    logic           clr_dwell, alert_start;
    logic [19:0]    sel_data;
    logic [5:0]     sel_dp;
    logic           sel_sign, seg_en_next;
    logic [19:0]    data_reg;
    logic [5:0]     dp_reg;
    logic           sign_reg, seg_en_reg;
    logic [1:0]     cur_src_reg;

    ms_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .tick    (tick)
    );

    assign alert_edge = alert_req & ~alert_req_reg;
    assign dwell_done = tick && (dwell_cnt_reg == TW'(DWELL_MS - 1));
    assign alert_done = tick && (alert_cnt_reg == TW'(ALERT_MS - 1));
    assign blink_done = tick && (blink_cnt_reg == TW'(BLINK_MS - 1));

    // Decision order: alert edge, then own-valid drop, then dwell expiry.
    always_comb begin
        state_next  = state_reg;
        ret_next    = ret_reg;
        clr_dwell   = 1'b0;
        alert_start = 1'b0;
        if (alert_edge) begin
            state_next  = ST_ALERT;
            alert_start = 1'b1;
            if (state_reg != ST_ALERT)
                ret_next = src_of(state_reg);
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = return_state(SRC_CH0, ch0_vld, ch1_vld);
                ST_SHOW0: begin
                    if (!ch0_vld)
                        state_next = ch1_vld ? ST_SHOW1 : ST_IDLE;
                    else if (dwell_done) begin
                        clr_dwell = 1'b1;
                        if (ch1_vld)
                            state_next = ST_SHOW1;
                    end
                end
                ST_SHOW1: begin
                    if (!ch1_vld)
                        state_next = ch0_vld ? ST_SHOW0 : ST_IDLE;
                    else if (dwell_done) begin
                        clr_dwell = 1'b1;
                        if (ch0_vld)
                            state_next = ST_SHOW0;
                    end
                end
                ST_ALERT: begin
                    if (alert_done)
                        state_next = return_state(ret_reg, ch0_vld, ch1_vld);
                end
                default:  state_next = ST_IDLE;
            endcase
        end
        if (state_next != state_reg)
            clr_dwell = 1'b1;
    end

    always_comb begin
        sel_data    = '0;
        sel_dp      = '0;
        sel_sign    = 1'b0;
        seg_en_next = 1'b0;
        case (state_next)
            ST_SHOW0: begin
                sel_data = ch0_data; sel_dp = ch0_dp; sel_sign = ch0_sign; seg_en_next = 1'b1;
            end
            ST_SHOW1: begin
                sel_data = ch1_data; sel_dp = ch1_dp; sel_sign = ch1_sign; seg_en_next = 1'b1;
            end
            ST_ALERT: begin
                sel_data    = alert_data; sel_dp = alert_dp; sel_sign = alert_sign;
                seg_en_next = alert_start ? 1'b1 : (blink_done ? ~seg_en_reg : seg_en_reg);
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg     <= ST_IDLE;
            ret_reg       <= SRC_IDLE;
            alert_req_reg <= 1'b0;
            dwell_cnt_reg <= '0;
            alert_cnt_reg <= '0;
            blink_cnt_reg <= '0;
            data_reg      <= '0;
            dp_reg        <= '0;
            sign_reg      <= 1'b0;
            seg_en_reg    <= 1'b0;
            cur_src_reg   <= SRC_IDLE;
        end else begin
            state_reg     <= state_next;
            ret_reg       <= ret_next;
            alert_req_reg <= alert_req;

            if (clr_dwell)
                dwell_cnt_reg <= '0;
            else if (tick)
                dwell_cnt_reg <= dwell_cnt_reg + 1'b1;

            if (alert_start)
                alert_cnt_reg <= '0;
            else if (tick && state_reg == ST_ALERT)
                alert_cnt_reg <= alert_cnt_reg + 1'b1;

            if (alert_start || blink_done)
                blink_cnt_reg <= '0;
            else if (tick && state_reg == ST_ALERT)
                blink_cnt_reg <= blink_cnt_reg + 1'b1;

            data_reg    <= (sel_data > DISP_MAX) ? DISP_MAX : sel_data;
            dp_reg      <= sel_dp;
            sign_reg    <= sel_sign;
            seg_en_reg  <= seg_en_next;
            cur_src_reg <= src_of(state_next);
        end
    end

    assign data    = data_reg;
    assign dp      = dp_reg;
    assign sign    = sign_reg;
    assign seg_en  = seg_en_reg;
    assign cur_src = cur_src_reg;

endmodule

// File: tb/tb_seg_disp_scheduler.sv
// Directed + randomized bench for seg_disp_scheduler, checked every cycle against a
// tick-timestamp reference model of the scheduling rules.
module tb_seg_disp_scheduler;
    localparam int CLK_FREQ_HZ = 10_000;
    localparam int DWELL_MS    = 5;
    localparam int ALERT_MS    = 8;
    localparam int BLINK_MS    = 2;
    localparam int DIV         = CLK_FREQ_HZ / 1000;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [19:0] ch0_data, ch1_data, alert_data;
    logic [5:0]  ch0_dp, ch1_dp, alert_dp;
    logic        ch0_sign, ch1_sign, alert_sign;
    logic        ch0_vld, ch1_vld, alert_req;
    logic [19:0] data;
    logic [5:0]  dp;
    logic        sign, seg_en;
    logic [1:0]  cur_src;

    int checks = 0;
    int errors = 0;

    // Reference model state: source shown, tick timestamps of entry / alert start.
    int          m_src, m_ret, m_edges, m_ticks, m_entry_t, m_alert_t;
    bit          m_prev;
    logic [19:0] m_data;
    logic [5:0]  m_dp;
    logic        m_sign, m_en;

    seg_disp_scheduler #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ), .DWELL_MS(DWELL_MS), .ALERT_MS(ALERT_MS), .BLINK_MS(BLINK_MS)
    ) dut (
        .sys_clk(clk), .sys_rst(sys_rst),
        .ch0_data(ch0_data), .ch0_dp(ch0_dp), .ch0_sign(ch0_sign), .ch0_vld(ch0_vld),
        .ch1_data(ch1_data), .ch1_dp(ch1_dp), .ch1_sign(ch1_sign), .ch1_vld(ch1_vld),
        .alert_data(alert_data), .alert_dp(alert_dp), .alert_sign(alert_sign), .alert_req(alert_req),
        .data(data), .dp(dp), .sign(sign), .seg_en(seg_en), .cur_src(cur_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] clamp(input logic [19:0] d);
        return (d > 20'd999999) ? 20'd999999 : d;
    endfunction

    function automatic int pick(input int pref, input bit v0, input bit v1);
        if (pref == 2) return v1 ? 2 : (v0 ? 1 : 0);
        return v0 ? 1 : (v1 ? 2 : 0);
    endfunction

    task automatic model_reset();
        m_src = 0; m_ret = 0; m_edges = 0; m_ticks = 0;
        m_entry_t = 0; m_alert_t = 0; m_prev = 1'b0;
        m_data = '0; m_dp = '0; m_sign = 1'b0; m_en = 1'b0;
    endtask

    function automatic bit tick_now();
        return (m_edges % DIV == 0) && (m_edges != 0);
    endfunction

    function automatic bit dwell_due();
        return (m_src == 1 || m_src == 2) && tick_now() && (m_ticks + 1 - m_entry_t == DWELL_MS);
    endfunction

    task automatic model_step();
        bit tk, ae, own_v, oth_v;
        int nxt;
        tk = tick_now();
        ae = alert_req && !m_prev;
        m_edges++;
        m_prev = alert_req;
        if (tk) m_ticks++;
        nxt = m_src;
        if (ae) begin
            if (m_src != 3) m_ret = m_src;
            nxt = 3;
            m_alert_t = m_ticks;
        end else if (m_src == 0) begin
            nxt = pick(1, ch0_vld, ch1_vld);
        end else if (m_src == 3) begin
            if (tk && m_ticks - m_alert_t == ALERT_MS) nxt = pick(m_ret, ch0_vld, ch1_vld);
        end else begin
            own_v = (m_src == 1) ? ch0_vld : ch1_vld;
            oth_v = (m_src == 1) ? ch1_vld : ch0_vld;
            if (!own_v) nxt = oth_v ? 3 - m_src : 0;
            else if (tk && m_ticks - m_entry_t == DWELL_MS) begin
                m_entry_t = m_ticks;
                if (oth_v) nxt = 3 - m_src;
            end
        end
        if (nxt != m_src) m_entry_t = m_ticks;
        m_src = nxt;
        case (m_src)
            1: begin m_data = clamp(ch0_data); m_dp = ch0_dp; m_sign = ch0_sign; m_en = 1'b1; end
            2: begin m_data = clamp(ch1_data); m_dp = ch1_dp; m_sign = ch1_sign; m_en = 1'b1; end
            3: begin
                m_data = clamp(alert_data); m_dp = alert_dp; m_sign = alert_sign;
                m_en = (((m_ticks - m_alert_t) / BLINK_MS) % 2) == 0;
            end
            default: begin m_data = '0; m_dp = '0; m_sign = 1'b0; m_en = 1'b0; end
        endcase
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check("model_cur_src", 32'(cur_src), 32'(m_src));
        check("model_data", 32'(data), 32'(m_data));
        check("model_dp", 32'(dp), 32'(m_dp));
        check("model_sign", 32'(sign), 32'(m_sign));
        check("model_seg_en", 32'(seg_en), 32'(m_en));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Cycles until cur_src differs from 'from' (or equals 'to' when to>=0); 0 means timeout.
    task automatic wait_src(input int to, input int from, input int limit, output int k);
        k = 0;
        for (int i = 1; i <= limit; i++) begin
            cyc();
            if ((to >= 0 && cur_src == 2'(to)) || (to < 0 && cur_src != 2'(from))) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_dp"}, 32'(dp), 32'd0);
        check({tag, "_sign"}, 32'(sign), 32'd0);
        check({tag, "_seg_en"}, 32'(seg_en), 32'd0);
        check({tag, "_cur_src"}, 32'(cur_src), 32'd0);
    endtask

    initial begin
        int k;
        bit hit;
        sys_rst = 1'b1;
        ch0_data = '0; ch0_dp = '0; ch0_sign = 1'b0; ch0_vld = 1'b0;
        ch1_data = '0; ch1_dp = '0; ch1_sign = 1'b0; ch1_vld = 1'b0;
        alert_data = '0; alert_dp = '0; alert_sign = 1'b0; alert_req = 1'b0;
        #2;
        check_reset_outputs("reset");
        #10;
        sys_rst = 1'b0;
        model_reset();

        // Rotation
        ch0_vld = 1'b1; ch1_vld = 1'b1; ch0_data = 20'd123; ch1_data = 20'd456;
        cyc();
        check("rot_first_src", 32'(cur_src), 32'd1);
        check("rot_first_data", 32'(data), 32'd123);
        wait_src(2, 0, 60, k);
        check("rot_to_ch1_cycles", 32'(k), 32'd50);
        check("rot_ch1_data", 32'(data), 32'd456);
        wait_src(1, 0, 60, k);
        check("rot_back_cycles", 32'(k), 32'd50);

        // Dropout
        ch1_vld = 1'b0;
        run(60);
        check("drop_stays_show0", 32'(cur_src), 32'd1);
        ch0_vld = 1'b0;
        cyc();
        check("drop_idle_src", 32'(cur_src), 32'd0);
        check("drop_idle_en", 32'(seg_en), 32'd0);

        // Alert from SHOW1, held high for longer than the alert
        ch1_vld = 1'b1; ch1_data = 20'($urandom_range(0, 999999));
        cyc();
        check("alert_pre_src", 32'(cur_src), 32'd2);
        run($urandom_range(3, 20));
        alert_data = 20'd7; alert_req = 1'b1;
        cyc();
        check("alert_src", 32'(cur_src), 32'd3);
        check("alert_data", 32'(data), 32'd7);
        check("alert_en_entry", 32'(seg_en), 32'd1);
        wait_src(-1, 3, 100, k);
        check("alert_len_ok", 32'(k >= 71 && k <= 80), 32'd1);
        check("alert_return_src", 32'(cur_src), 32'd2);
        run(30);
        check("alert_held_no_retrigger", 32'(cur_src), 32'd2);
        alert_req = 1'b0;

        // Restart 40 cycles into the alert
        ch0_vld = 1'b1;
        cyc();
        alert_req = 1'b1;
        cyc();
        alert_req = 1'b0;
        run(39);
        check("restart_still_alert", 32'(cur_src), 32'd3);
        alert_req = 1'b1;
        cyc();
        alert_req = 1'b0;
        wait_src(-1, 3, 100, k);
        check("restart_len_ok", 32'(k >= 71 && k <= 80), 32'd1);

        // Alert edge on the same cycle as dwell expiry
        hit = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (dwell_due()) begin
                alert_req = 1'b1;
                cyc();
                check("collision_alert_src", 32'(cur_src), 32'd3);
                hit = 1'b1;
                break;
            end
            cyc();
        end
        check("collision_found", 32'(hit), 32'd1);
        alert_req = 1'b0;
        wait_src(-1, 3, 100, k);
        check("collision_exit_found", 32'(k != 0), 32'd1);

        // Clamp
        ch0_data = 20'hFFFFF; ch0_dp = 6'b000100; ch0_sign = 1'b1;
        wait_src(1, 0, 120, k);
        check("clamp_found", 32'(k != 0), 32'd1);
        check("clamp_data", 32'(data), 32'd999999);
        check("clamp_dp", 32'(dp), 32'b000100);
        check("clamp_sign", 32'(sign), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ch0_data = 20'($urandom); ch1_data = 20'($urandom); alert_data = 20'($urandom);
            ch0_dp = 6'($urandom); ch1_dp = 6'($urandom); alert_dp = 6'($urandom);
            ch0_sign = 1'($urandom); ch1_sign = 1'($urandom); alert_sign = 1'($urandom);
            if ($urandom_range(0, 15) == 0) ch0_vld = ~ch0_vld;
            if ($urandom_range(0, 15) == 0) ch1_vld = ~ch1_vld;
            if ($urandom_range(0, 39) == 0) alert_req = ~alert_req;
            cyc();
        end

        // Asynchronous reset mid-alert
        alert_req = 1'b0; ch0_vld = 1'b1; ch1_vld = 1'b0;
        cyc();
        alert_req = 1'b1;
        cyc();
        check("arst_pre_src", 32'(cur_src), 32'd3);
        #3;
        sys_rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        alert_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        sys_rst = 1'b0;
        model_reset();
        cyc();
        check("arst_resume_src", 32'(cur_src), 32'd1);
        check("arst_resume_en", 32'(seg_en), 32'd1);
        run(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
